move_scheduler_2048: RTL

- Sits between the synchronised push-buttons and the 2048 board-logic datapath.
- Edge-detects presses and queues them in a small FIFO.
- Issues one move at a time to the datapath over a valid/ready + done handshake, and counts turns.
- After a win/loss it runs the end-screen timer and sequences the board clear.

---
 rtl/move_scheduler_2048.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/move_scheduler_2048.sv
// Button-to-move scheduler for the 2048 board datapath: press detection, move FIFO,
// issue handshake, turn counter and end-screen/clear sequencing. Optional: MOVE_SCHEDULER_REPEAT_EN.
module move_scheduler_2048 #(
  parameter int QUEUE_DEPTH   = 4,
  parameter int SCREEN_CYCLES = 1200,
  parameter int TURN_WIDTH    = 14,
  parameter int REPEAT_CYCLES = 65536
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btnL,
  input  logic                  btnR,
  input  logic                  btnU,
  input  logic                  btnD,
  output logic                  move_valid,
  output logic [1:0]            move_dir,
  input  logic                  move_ready,
  input  logic                  move_done,
  input  logic                  won,
  input  logic                  lost,
  output logic                  clear_req,
  input  logic                  clear_ack,
  output logic [TURN_WIDTH-1:0] turns,
  output logic                  game_over,
  output logic                  queue_overflow
);

  localparam int PTR_W   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int TIMER_W = (SCREEN_CYCLES > 1) ? $clog2(SCREEN_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SCREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DEPTH_C    = CNT_W'(QUEUE_DEPTH);

  if (QUEUE_DEPTH < 2 || QUEUE_DEPTH > 16 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0 ||
      REPEAT_CYCLES < 2 || SCREEN_CYCLES < 1) begin : g_bad_params
    $error("move_scheduler_2048: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, OVER, CLEAR} state_e;

  state_e                 state_q;
  logic [3:0]             last_q;
  logic                   move_valid_q;
  logic [1:0]             move_dir_q;
  logic                   clear_req_q;
  logic                   game_over_q;
  logic                   overflow_q;
  logic [TURN_WIDTH-1:0]  turns_q;
  logic [TIMER_W-1:0]     timer_q;

  logic [1:0]             mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic [3:0]             btn_now;
  logic [3:0]             edge_press;
  logic [3:0]             press_raw;
  logic                   any_press;
  logic [1:0]             sel_dir;
  logic                   enq_state;
  logic                   fifo_full;
  logic                   deq;
  logic                   enq;
  logic                   drop;
  logic                   going_over;

  // Bit index equals the move_dir encoding: L=0, R=1, U=2, D=3.
  assign btn_now    = {btnD, btnU, btnR, btnL};
  assign edge_press = btn_now & ~last_q;
  assign going_over = (state_q == BUSY) && move_done && (won || lost);

`ifdef MOVE_SCHEDULER_REPEAT_EN
  localparam int HOLD_W = $clog2(REPEAT_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REPEAT_CYCLES - 1);

  logic [3:0]        active_q;
  logic [HOLD_W-1:0] hold_q [4];
  logic [3:0]        repeat_press;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      repeat_press[i] = active_q[i] && btn_now[i] && (hold_q[i] == HOLD_LAST);
    end
  end

  // Only a real rising edge arms a direction, so a button held through reset never repeats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= '0;
      for (int i = 0; i < 4; i++) hold_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!btn_now[i] || going_over || state_q == OVER) begin
          active_q[i] <= 1'b0;
          hold_q[i]   <= '0;
        end else if (edge_press[i]) begin
          active_q[i] <= 1'b1;
          hold_q[i]   <= '0;
        end else if (active_q[i]) begin
          hold_q[i] <= repeat_press[i] ? '0 : hold_q[i] + 1'b1;
        end
      end
    end
  end

  assign press_raw = edge_press | repeat_press;
`else
  assign press_raw = edge_press;
`endif

  always_comb begin
    sel_dir = 2'd0;
    if (press_raw[2])      sel_dir = 2'd2;
    else if (press_raw[3]) sel_dir = 2'd3;
    else if (press_raw[0]) sel_dir = 2'd0;
    else if (press_raw[1]) sel_dir = 2'd1;
  end

  assign any_press = |press_raw;
  assign enq_state = (state_q == IDLE) || (state_q == ISSUE) || (state_q == BUSY);
  assign fifo_full = (count_q == DEPTH_C);
  assign deq       = (state_q == IDLE) && (count_q != '0);
  assign enq       = any_press && enq_state && (!fifo_full || deq);
  assign drop      = any_press && enq_state && fifo_full && !deq;

  // Entering OVER flushes the queue, overriding any same-cycle enqueue.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (going_over) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
      if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
      if (enq && !deq)      count_d = count_q + 1'b1;
      else if (!enq && deq) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= sel_dir;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= 4'hF;
      move_valid_q <= 1'b0;
      move_dir_q   <= 2'd0;
      clear_req_q  <= 1'b0;
      game_over_q  <= 1'b0;
      overflow_q   <= 1'b0;
      turns_q      <= '0;
      timer_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      last_q     <= btn_now;
      overflow_q <= drop;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      case (state_q)
        IDLE: begin
          if (deq) begin
            move_dir_q   <= mem_q[rd_ptr_q];
            move_valid_q <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (move_ready) begin
            move_valid_q <= 1'b0;
            if (turns_q != '1) turns_q <= turns_q + 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (going_over) begin
            timer_q     <= '0;
            game_over_q <= 1'b1;
            state_q     <= OVER;
          end else if (move_done) begin
            state_q <= IDLE;
          end
        end
        OVER: begin
          if (timer_q == TIMER_LAST) begin
            clear_req_q <= 1'b1;
            state_q     <= CLEAR;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        CLEAR: begin
          if (clear_ack) begin
            clear_req_q <= 1'b0;
            game_over_q <= 1'b0;
            turns_q     <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign move_valid     = move_valid_q;
  assign move_dir       = move_dir_q;
  assign clear_req      = clear_req_q;
  assign game_over      = game_over_q;
  assign queue_overflow = overflow_q;
  assign turns          = turns_q;

endmodule
